// File: rtl/difftest_commit_sched_pkg.sv
// rtl/difftest_commit_sched_pkg.sv - shared widths, FSM states and commit record layout
package difftest_commit_sched_pkg;

   localparam int DATA_WIDTH = 32;

   // Record layout: {pc, instr, npc, skip, ebreak}
   localparam int COMMIT_W = 3 * DATA_WIDTH + 2;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2,
      ST_HUNG   = 2'd3
   } state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] instr;
      logic [DATA_WIDTH-1:0] npc;
      logic                  skip;
      logic                  ebreak;
   } commit_t;

endpackage

// File: rtl/difftest_commit_sched_if.sv
// rtl/difftest_commit_sched_if.sv - WB commit and difftest handshake bundle
// Ports (signals):
//   wb_valid/wb_ready + wb_pc/wb_instr/wb_npc/wb_skip/wb_ebreak : retire side
//   diff_valid/diff_ready + diff_pc/diff_instr/diff_npc/diff_skip : checker side
// master: simulation environment (drives WB, consumes commits)
// slave : commit scheduler
interface difftest_commit_sched_if;
   import difftest_commit_sched_pkg::*;

   logic                  wb_valid;
   logic                  wb_ready;
   logic [DATA_WIDTH-1:0] wb_pc;
   logic [DATA_WIDTH-1:0] wb_instr;
   logic [DATA_WIDTH-1:0] wb_npc;
   logic                  wb_skip;
   logic                  wb_ebreak;

   logic                  diff_valid;
   logic                  diff_ready;
   logic [DATA_WIDTH-1:0] diff_pc;
   logic [DATA_WIDTH-1:0] diff_instr;
   logic [DATA_WIDTH-1:0] diff_npc;
   logic                  diff_skip;

   modport master (
      output wb_valid, wb_pc, wb_instr, wb_npc, wb_skip, wb_ebreak, diff_ready,
      input  wb_ready, diff_valid, diff_pc, diff_instr, diff_npc, diff_skip
   );

   modport slave (
      input  wb_valid, wb_pc, wb_instr, wb_npc, wb_skip, wb_ebreak, diff_ready,
      output wb_ready, diff_valid, diff_pc, diff_instr, diff_npc, diff_skip
   );

endinterface

// File: rtl/difftest_fifo.sv
// rtl/difftest_fifo.sv - show-ahead synchronous FIFO with fill count
// Ports:
//   clk, rst          : clock, synchronous active-high reset (clears storage too)
//   wr_en, wr_data    : push (ignored when full)
//   rd_en, rd_data    : pop (ignored when empty); rd_data is always the head
//   full, empty, count: status
module difftest_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_wr) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/difftest_commit_sched.sv
// rtl/difftest_commit_sched.sv - orders WB commits towards the difftest checker
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : slave side of the WB/difftest handshake bundle
//   halt      : ebreak committed and all commits drained
//   hang      : no enqueue/dequeue for TIMEOUT cycles
//   occupancy : queued commit count
module difftest_commit_sched
   import difftest_commit_sched_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic                   clk,
   input  logic                   rst,
   difftest_commit_sched_if.slave bus,
   output logic                   halt,
   output logic                   hang,
   output logic [$clog2(DEPTH):0] occupancy
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int IW = $clog2(TIMEOUT + 1);

   state_t        state;
   state_t        state_nxt;
   commit_t       wr_rec;
   commit_t       rd_rec;
   logic          full;
   logic          empty;
   logic          enq;
   logic          deq;
   logic          timeout;
   logic [CW-1:0] count;
   logic [IW-1:0] idle;

   assign bus.wb_ready   = !full && (state == ST_RUN) && !rst;
   assign bus.diff_valid = !empty && (state != ST_HUNG);
   assign enq            = bus.wb_valid && bus.wb_ready;
   assign deq            = bus.diff_valid && bus.diff_ready;

   assign wr_rec = '{pc: bus.wb_pc, instr: bus.wb_instr, npc: bus.wb_npc,
                     skip: bus.wb_skip, ebreak: bus.wb_ebreak};

   difftest_fifo #(.WIDTH(COMMIT_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (enq),
      .wr_data (wr_rec),
      .rd_en   (deq),
      .rd_data (rd_rec),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   assign bus.diff_pc    = rd_rec.pc;
   assign bus.diff_instr = rd_rec.instr;
   assign bus.diff_npc   = rd_rec.npc;
   assign bus.diff_skip  = rd_rec.skip;

   assign occupancy = count;
   assign halt      = (state == ST_HALTED);
   assign hang      = (state == ST_HUNG);
   assign timeout   = (idle == IW'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // In DRAIN nothing is enqueued after the ebreak, so popping the ebreak
   // entry empties the queue; that pop beats a coinciding timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN: begin
            if (timeout) begin
               state_nxt = ST_HUNG;
            end else if (enq && bus.wb_ebreak) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((count == '0) || (deq && rd_rec.ebreak)) begin
               state_nxt = ST_HALTED;
            end else if (timeout) begin
               state_nxt = ST_HUNG;
            end
         end
         default: state_nxt = state;
      endcase
   end

   // Idle counter saturates at TIMEOUT so a long hang never wraps back to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         idle <= '0;
      end else if ((state == ST_RUN) || (state == ST_DRAIN)) begin
         if (enq || deq) begin
            idle <= '0;
         end else if (!timeout) begin
            idle <= idle + IW'(1);
         end
      end
   end

endmodule

// File: tb/tb_difftest_commit_sched.sv
// tb/tb_difftest_commit_sched.sv - scoreboard bench for difftest_commit_sched
module tb_difftest_commit_sched;
   import difftest_commit_sched_pkg::*;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] npc;
      logic        skip;
   } rec_t;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   halt;
   logic                   hang;
   logic [$clog2(DEPTH):0] occupancy;

   difftest_commit_sched_if bus();

   difftest_commit_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .halt      (halt),
      .hang      (hang),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   int   tests = 0;
   int   fails = 0;
   rec_t sb[$];
   bit   chk_en   = 1'b0;
   bit   rnd_done = 1'b0;

   // Reference model: queue contents plus the run phase flags.
   bit   m_drain  = 1'b0;
   bit   m_halted = 1'b0;
   bit   m_hung   = 1'b0;
   int   m_idle   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      bus.wb_valid   = 1'b0;
      bus.diff_ready = 1'b0;
      cycle();
      rst = 1'b0;
   endtask

   // Holds a commit on WB until accepted; the accepted record becomes the
   // expected next output of the checker side.
   task automatic send(input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] npc, input logic skip, input logic ebreak);
      rec_t r;
      int   n = 0;
      bit   done = 1'b0;
      r.pc = pc; r.instr = instr; r.npc = npc; r.skip = skip;
      bus.wb_valid  = 1'b1;
      bus.wb_pc     = pc;
      bus.wb_instr  = instr;
      bus.wb_npc    = npc;
      bus.wb_skip   = skip;
      bus.wb_ebreak = ebreak;
      while (!done) begin
         @(negedge clk);
         if (bus.wb_ready) begin
            done = 1'b1;
            #1 sb.push_back(r);
         end else if (++n > 50) begin
            done = 1'b1;
            check("send_timeout", 64'(0), 64'(1));
         end
         @(posedge clk);
         #1;
      end
      bus.wb_valid  = 1'b0;
      bus.wb_ebreak = 1'b0;
   endtask

   // Monitor: compares every cycle against the model, pops on each dequeue.
   always @(negedge clk) begin
      bit   exp_ready, exp_valid, enq, deq, tmo, running;
      int   n_after;
      rec_t e;
      if (chk_en) begin
         exp_ready = !rst && !m_drain && !m_halted && !m_hung && (sb.size() < DEPTH);
         exp_valid = (sb.size() > 0) && !m_hung;
         check("wb_ready",   64'(bus.wb_ready),   64'(exp_ready));
         check("diff_valid", 64'(bus.diff_valid), 64'(exp_valid));
         check("occupancy",  64'(occupancy),      64'(sb.size()));
         check("halt",       64'(halt),           64'(m_halted));
         check("hang",       64'(hang),           64'(m_hung));
         if (rst) begin
            sb.delete();
            m_drain = 1'b0; m_halted = 1'b0; m_hung = 1'b0; m_idle = 0;
         end else begin
            enq     = bus.wb_valid && exp_ready;
            deq     = exp_valid && bus.diff_ready;
            n_after = sb.size() + int'(enq) - int'(deq);
            running = !m_halted && !m_hung;
            tmo     = (m_idle == TIMEOUT);
            if (deq) begin
               e = sb.pop_front();
               check("diff_pc",    64'(bus.diff_pc),    64'(e.pc));
               check("diff_instr", 64'(bus.diff_instr), 64'(e.instr));
               check("diff_npc",   64'(bus.diff_npc),   64'(e.npc));
               check("diff_skip",  64'(bus.diff_skip),  64'(e.skip));
            end
            if (running && !m_drain) begin
               if (tmo) m_hung = 1'b1;
               else if (enq && bus.wb_ebreak) m_drain = 1'b1;
            end else if (m_drain) begin
               if (n_after == 0) begin m_drain = 1'b0; m_halted = 1'b1; end
               else if (tmo) begin m_drain = 1'b0; m_hung = 1'b1; end
            end
            if (running) begin
               if (enq || deq) m_idle = 0;
               else if (m_idle < TIMEOUT) m_idle++;
            end
         end
      end
   end

   initial begin
      bus.wb_valid = 1'b0; bus.wb_pc = '0; bus.wb_instr = '0; bus.wb_npc = '0;
      bus.wb_skip = 1'b0; bus.wb_ebreak = 1'b0; bus.diff_ready = 1'b0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      rst    = 1'b0;
      @(negedge clk);
      check("rst_diff_pc",    64'(bus.diff_pc),    64'(0));
      check("rst_diff_instr", 64'(bus.diff_instr), 64'(0));
      check("rst_diff_npc",   64'(bus.diff_npc),   64'(0));
      check("rst_diff_skip",  64'(bus.diff_skip),  64'(0));
      check("rst_wb_ready",   64'(bus.wb_ready),   64'(1));
      cycle();

      // Single commit
      do_reset();
      bus.diff_ready = 1'b1;
      send(32'h8000_0000, 32'h0000_0013, 32'h8000_0004, 1'b0, 1'b0);
      repeat (3) cycle();

      // Backpressure: five commits into a four-deep queue
      do_reset();
      fork
         for (int i = 0; i < 5; i++)
            send(32'h8000_0100 + 32'(4 * i), 32'h0000_0013, 32'h8000_0104 + 32'(4 * i), 1'(i & 1), 1'b0);
         begin repeat (7) cycle(); bus.diff_ready = 1'b1; end
      join
      repeat (5) cycle();

      // Streaming at count == 2
      do_reset();
      send(32'h8000_1000, 32'h0010_0093, 32'h8000_1004, 1'b0, 1'b0);
      send(32'h8000_1004, 32'h0010_0093, 32'h8000_1008, 1'b0, 1'b0);
      bus.diff_ready = 1'b1;
      for (int i = 2; i < 12; i++)
         send(32'h8000_1000 + 32'(4 * i), 32'h0010_0093, 32'h8000_1004 + 32'(4 * i), 1'b0, 1'b0);
      repeat (4) cycle();

      // Randomized traffic
      do_reset();
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               send($urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
               repeat ($urandom_range(0, 2)) cycle();
            end
            rnd_done = 1'b1;
         end
         begin
            int zeros = 0;
            while (!rnd_done) begin
               if (zeros >= 2 || $urandom_range(0, 3) != 0) begin
                  bus.diff_ready = 1'b1; zeros = 0;
               end else begin
                  bus.diff_ready = 1'b0; zeros++;
               end
               cycle();
            end
         end
      join
      bus.diff_ready = 1'b1;
      repeat (5) cycle();

      // Ebreak drain and halt
      do_reset();
      send(32'h8000_2000, 32'h0000_0013, 32'h8000_2004, 1'b0, 1'b0);
      send(32'h8000_2004, 32'h0010_0073, 32'h8000_2008, 1'b0, 1'b1);
      repeat (3) cycle();
      bus.diff_ready = 1'b1;
      repeat (3) cycle();
      @(negedge clk);
      check("ebreak_halt", 64'(halt), 64'(1));
      cycle();
      bus.wb_valid = 1'b1;
      repeat (2) cycle();
      bus.wb_valid = 1'b0;

      // Last drain pop coinciding with timeout: halt wins
      do_reset();
      send(32'h8000_3000, 32'h0010_0073, 32'h8000_3004, 1'b1, 1'b1);
      repeat (TIMEOUT) cycle();
      bus.diff_ready = 1'b1;
      cycle();
      @(negedge clk);
      check("prio_halt", 64'(halt), 64'(1));
      check("prio_hang", 64'(hang), 64'(0));
      cycle();

      // Hang with an empty queue
      do_reset();
      repeat (12) cycle();
      @(negedge clk);
      check("hang_empty", 64'(hang), 64'(1));
      check("hang_empty_wb_ready", 64'(bus.wb_ready), 64'(0));
      cycle();

      // Hang with one entry held
      do_reset();
      send(32'h8000_4000, 32'h0000_0013, 32'h8000_4004, 1'b0, 1'b0);
      repeat (12) cycle();
      @(negedge clk);
      check("hang_entry", 64'(hang), 64'(1));
      check("hang_entry_valid", 64'(bus.diff_valid), 64'(0));
      cycle();

      // Reset mid-run discards queued entries
      do_reset();
      for (int i = 0; i < 3; i++)
         send(32'h8000_5000 + 32'(4 * i), 32'hdead_beef, 32'h8000_5004 + 32'(4 * i), 1'b1, 1'b0);
      do_reset();
      @(negedge clk);
      check("midrst_valid",    64'(bus.diff_valid), 64'(0));
      check("midrst_occ",      64'(occupancy),      64'(0));
      check("midrst_pc",       64'(bus.diff_pc),    64'(0));
      check("midrst_wb_ready", 64'(bus.wb_ready),   64'(1));
      cycle();
      bus.diff_ready = 1'b1;
      repeat (4) cycle();

      check("sb_empty_end", 64'(sb.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
